restoring_divider_seq: RTL and testbench

//   Sequential restoring divider; the inverse of the gate-level array multiplier.

---
 rtl/restoring_divider_seq.sv | 145 ++++++++++++++
 tb/tb_restoring_divider_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : restoring_divider_seq                                      |
// | Description : Sequential unsigned restoring divider, one quotient bit    |
// |               per clock. Optional divide-by-zero short cut enabled by    |
// |               defining RESTORING_DIV_ZERO_DETECT_EN.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module restoring_divider_seq #(
  parameter int DIVIDEND_W = 5,
  parameter int DIVISOR_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] c_count_init = CNT_W'(DIVIDEND_W);
  localparam logic [CNT_W-1:0] c_count_last = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_accept;
  logic                   w_zero_skip;

  // r_qd starts as the dividend; each iteration shifts its MSB into the
  // partial remainder and a quotient bit in at the LSB.
  logic [DIVIDEND_W-1:0]  r_qd;
  logic [DIVISOR_W-1:0]   r_divisor;
  logic [DIVISOR_W-1:0]   r_rem;
  logic [CNT_W-1:0]       r_count;

  logic [DIVISOR_W:0]     w_shift;
  logic                   w_ge;
  logic [DIVISOR_W-1:0]   w_rem_next;
  logic [DIVIDEND_W-1:0]  w_qd_next;

`ifdef RESTORING_DIV_ZERO_DETECT_EN
  assign w_zero_skip = (divisor == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = w_zero_skip ? S_DONE : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_count == c_count_last) begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Low remainder bits of the difference only depend on the low operand bits,
  // so the subtraction can be done at DIVISOR_W width once w_ge is known.
  assign w_shift    = {r_rem, r_qd[DIVIDEND_W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_rem_next = w_ge ? (w_shift[DIVISOR_W-1:0] - r_divisor) : w_shift[DIVISOR_W-1:0];
  assign w_qd_next  = {r_qd[DIVIDEND_W-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_qd      <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (w_accept) begin
      r_qd      <= dividend;
      r_divisor <= divisor;
      r_rem     <= '0;
      r_count   <= c_count_init;
      if (w_zero_skip) begin
        quotient  <= '1;
        remainder <= dividend[DIVISOR_W-1:0];
      end
    end else if (r_state == S_RUN) begin
      r_qd    <= w_qd_next;
      r_rem   <= w_rem_next;
      r_count <= r_count - CNT_W'(1);
      if (r_count == c_count_last) begin
        quotient  <= w_qd_next;
        remainder <= w_rem_next;
      end
    end
  end

`ifdef RESTORING_DIV_ZERO_DETECT_EN
  logic r_div_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_div_zero <= w_zero_skip;
    end
  end

  assign div_zero = r_div_zero;
`else
  assign div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_restoring_divider_seq                                   |
// | Description : Scoreboard bench for restoring_divider_seq (5/2 defaults). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_restoring_divider_seq;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic [4:0] dividend  = '0;
  logic [1:0] divisor   = '0;
  logic       busy;
  logic       done;
  logic [4:0] quotient;
  logic [1:0] remainder;
  logic       div_zero;

  typedef struct packed {
    logic [4:0] q;
    logic [1:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef RESTORING_DIV_ZERO_DETECT_EN
  localparam int   ZERO_LAT  = 1;
  localparam logic ZERO_FLAG = 1'b1;
`else
  localparam int   ZERO_LAT  = 6;
  localparam logic ZERO_FLAG = 1'b0;
`endif

  always #5 clk = ~clk;

  restoring_divider_seq #(
    .DIVIDEND_W (5),
    .DIVISOR_W  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap: got busy=1 done=1, required never both");
    end
    if (done) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with q=%0d r=%0d, required no done", quotient, remainder);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_zero} !== e) begin
          errors++;
          $display("FAIL result: got q=%0d r=%0d dz=%0d, required q=%0d r=%0d dz=%0d",
                   quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
      end
    end
  end

  task automatic run_op(input logic [4:0] a, input logic [1:0] b, input logic [4:0] eq,
                        input logic [1:0] er, input logic edz, input int exp_lat, input string name);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(exp_t'({eq, er, edz}));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy"}, 32'(busy_ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat1;
    int lat2;
    repeat (3) @(negedge clk);
    check("reset_busy_done", {busy, done}, 0);
    check("reset_results", {quotient, remainder, div_zero}, 0);
    rst_n = 1'b1;

    run_op(5'd27, 2'd3, 5'd9, 2'd0, 1'b0, 6, "div_27_3");
    repeat (3) @(negedge clk);
    check("hold_quotient", quotient, 9);

    run_op(5'd31, 2'd2, 5'd15, 2'd1, 1'b0, 6, "div_31_2");
    run_op(5'd7, 2'd3, 5'd2, 2'd1, 1'b0, 6, "div_7_3");
    run_op(5'd0, 2'd1, 5'd0, 2'd0, 1'b0, 6, "div_0_1");

    // Back-to-back: start held through DONE of 31/2, then 6/3 accepted there.
    lat1 = 0;
    lat2 = 0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 5'd31;
    divisor  = 2'd2;
    sb.push_back(exp_t'({5'd15, 2'd1, 1'b0}));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat1 = k;
        break;
      end
    end
    dividend = 5'd6;
    divisor  = 2'd3;
    sb.push_back(exp_t'({5'd2, 2'd0, 1'b0}));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        lat2 = k;
        break;
      end
    end
    check("b2b_first_latency", lat1, 6);
    check("b2b_second_latency", lat2, 6);

    run_op(5'd22, 2'd0, 5'd31, 2'd2, ZERO_FLAG, ZERO_LAT, "div_22_0");
    run_op(5'd5, 2'd1, 5'd5, 2'd0, 1'b0, 6, "div_5_1");

    // start pulsed mid-RUN with new operands must be ignored.
    lat1 = 0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 5'd7;
    divisor  = 2'd3;
    sb.push_back(exp_t'({5'd2, 2'd1, 1'b0}));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        start    = 1'b1;
        dividend = 5'd31;
        divisor  = 2'd2;
      end
      if (k == 3) start = 1'b0;
      if (done) begin
        lat1 = k;
        break;
      end
    end
    check("ignored_start_latency", lat1, 6);
    repeat (10) @(negedge clk);

    // Reset during RUN aborts: no done, results cleared.
    @(negedge clk);
    start    = 1'b1;
    dividend = 5'd27;
    divisor  = 2'd3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) rst_n = 1'b0;
    end
    @(negedge clk);
    check("abort_busy_done", {busy, done}, 0);
    check("abort_results", {quotient, remainder}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int a = 0; a < 32; a++) begin
      for (int b = 1; b < 4; b++) begin
        run_op(5'(a), 2'(b), 5'(a / b), 2'(a % b), 1'b0, 6, $sformatf("sweep_%0d_%0d", a, b));
      end
    end

    // Round trip: (x*y)/x must give back y with no remainder.
    for (int x = 1; x < 4; x++) begin
      for (int y = 0; y < 8; y++) begin
        run_op(5'(x * y), 2'(x), 5'(y), 2'd0, 1'b0, 6, $sformatf("roundtrip_%0d_%0d", x, y));
      end
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
